// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family: direction encoding and
// a constant-foldable ceil(log2) used to size prescaler registers.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int unsigned clog2(input longint unsigned value);
        int unsigned     r;
        longint unsigned span;
        r    = 0;
        span = 1;
        while (span < value) begin
            span = span << 1;
            r    = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 (DIV = CLK_FREQ/TICK_HZ) and emits a registered
// one-cycle tick in the cycle after the count holds DIV-1.
module tick_gen
    import counter_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 12000000,
    parameter int unsigned TICK_HZ  = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV  = (TICK_HZ == 0) ? 0 : CLK_FREQ / TICK_HZ;
    localparam int unsigned CW   = (DIV > 1) ? clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $error("tick_gen: CLK_FREQ/TICK_HZ must be at least 1");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_q == LAST);
        if (clr) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter stepped by a prescaled tick, with clear/load priority.
// Define MOD_COUNTER_SATURATE_EN to hold at the bounds instead of wrapping.
module mod_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter longint      MODULO   = 16,
    parameter int unsigned CLK_FREQ = 12000000,
    parameter int unsigned TICK_HZ  = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] q_n,
    output logic             tc,
    output logic             wrap,
    output logic             tick
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mod_counter: WIDTH must be in 1..32");
    end
    if (MODULO < 2 || MODULO > (longint'(1) << WIDTH)) begin : g_bad_modulo
        $error("mod_counter: MODULO must be in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             step;

    tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .tick (tick)
    );

    assign step = tick & en;

    // clr beats load beats step; the losing actions are simply dropped.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                if (count_q == MAX_VAL) begin
`ifdef MOD_COUNTER_SATURATE_EN
                    count_d = MAX_VAL;
`else
                    count_d = '0;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
`ifdef MOD_COUNTER_SATURATE_EN
                    count_d = '0;
`else
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign q_n   = ~count_q;
    assign wrap  = wrap_q;
    assign tc    = ((up_dn == DIR_UP)   && (count_q == MAX_VAL)) ||
                   ((up_dn == DIR_DOWN) && (count_q == '0));

endmodule
